ustream_win_cnt: RTL and testbench
==================================

Name: ustream_win_cnt

Overview:
- Downstream consumer of the unary square-root kernel's output bitstream.
- Counts the ones in a power-of-two window of enabled cycles and converts the unary result back to binary for the downstream datapath and the testbench.
- Provides a start/busy/done handshake, a raw ones count, and a value normalised to a fixed WLOG-bit scale.

Parameters:
WLOG, 8, log2 of the maximum window length; maximum window is 2^WLOG enabled samples
KW, 4, width of win_log; must satisfy 2^KW > WLOG

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
start  input  1  begin a new measurement window; single-cycle pulse expected
win_log  input  KW  window length exponent k; window is 2^k enabled samples; sampled only when start is accepted
in_bit  input  1  unary bitstream sample, e.g. the square-root kernel's out
in_en  input  1  sample qualifier; only cycles with in_en=1 are counted
busy  output  1  high while a window is in progress
done  output  1  one-cycle pulse when a window completes
count  output  WLOG+1  number of ones in the last completed window
value  output  WLOG  count scaled to 2^WLOG full scale, saturated
ones_live  output  WLOG+1  running ones count of the current window, for debug

Behaviour:
- Reset (async): state IDLE; busy=0, done=0, count=0, value=0, ones_live=0; internal sample counter=0.
- Mid-window reset: aborts the window silently; no done pulse; count and value return to 0.
- FSM has two states, IDLE and RUN. busy = (state==RUN).
- IDLE:
  - start=1 at a rising edge latches k=min(win_log, WLOG), clears the ones and sample counters, and moves to RUN.
  - in_bit is not sampled at the start edge.
- RUN, each edge with in_en=1:
  - ones += in_bit.
  - sample counter += 1.
  - in_en=0: both counters hold.
- Completion:
  - On the edge that accepts the 2^k-th enabled sample, that sample is included in the result.
  - count and value load at that edge, done=1 for exactly the following cycle, and the FSM returns to IDLE.
  - A start in the done cycle is accepted, so back-to-back windows lose zero cycles.
- Latency: with in_en held high, done is visible 2^k+1 cycles after the start cycle; start at edge E0, samples at E1..E(2^k), done high after E(2^k).
- start in RUN: restarts immediately. The current window is discarded with no done pulse, and count/value keep their previous values. A new k is latched, counters clear, and sampling begins at the next edge.
- Arithmetic:
  - ones counter is WLOG+1 bits; the maximum 2^WLOG is exact with no wrap.
  - Sample counter is WLOG+1 bits and compared against 2^k.
  - value = count << (WLOG-k); if the result is ≥ 2^WLOG, value = 2^WLOG-1 (saturate).
- count and value hold between done pulses.
- ones_live shows the ones counter every cycle: the current window in RUN, the last window's total in IDLE.
- k=0 is a one-sample window; value = 2^WLOG-1 if that sample is 1, else 0.
- win_log > WLOG clamps to WLOG.
- start with simultaneous in_en=1 in IDLE: that sample is not counted.

Test Plan:
1. WLOG=8, start with win_log=3, in_en=1, bits 1,0,1,1,0,0,1,0 -> done 9 cycles after start; count=4; value=128; busy high for exactly 8 cycles.
2. win_log=8, in_bit=1 constant -> count=256; value=255 (saturated); no counter wrap.
3. win_log=2, in_en pattern 1,0,1,0,0,1,1 with in_bit=1 throughout -> only enabled samples counted; done follows the 4th enabled sample; count=4; value=255.
4. win_log=4 run; at the 3rd sample assert start with win_log=1, then bits 1,1 -> no done for the first window; done 3 cycles after restart; count=2; value=255.
5. win_log=0, first enabled bit 0 -> count=0, value=0. Then start with win_log=12 and bits all 0 -> window clamps to 256 samples, count=0.
6. Assert rst_n low at sample 5 of a win_log=3 window -> busy, done, count, value all 0 immediately. After release, a start with alternating bits and win_log=3 -> count=4, value=128.

Source files
------------

// File: rtl/ustream_win_cnt.sv
// Unary bitstream window counter: counts ones over 2^k enabled samples and
// converts the result back to binary, raw and normalised to a 2^WLOG scale.
module ustream_win_cnt #(
    parameter int unsigned WLOG = 8,
    parameter int unsigned KW   = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [KW-1:0]   win_log,
    input  logic            in_bit,
    input  logic            in_en,
    output logic            busy,
    output logic            done,
    output logic [WLOG:0]   count,
    output logic [WLOG-1:0] value,
    output logic [WLOG:0]   ones_live
);

    typedef enum logic {StIdle, StRun} state_t;

    state_t          state_q, state_d;
    logic [KW-1:0]   k_q, k_d;
    logic [WLOG:0]   ones_q, ones_d;
    logic [WLOG:0]   samp_q, samp_d;
    logic [WLOG:0]   count_q, count_d;
    logic [WLOG-1:0] value_q, value_d;
    logic            done_q, done_d;

    logic [KW-1:0]   k_clamp;
    logic [KW-1:0]   shamt;
    logic [WLOG:0]   ones_inc;
    logic [WLOG:0]   samp_inc;
    logic [WLOG:0]   target;
    logic [WLOG:0]   scaled;

    assign k_clamp  = (win_log > KW'(WLOG)) ? KW'(WLOG) : win_log;
    assign ones_inc = ones_q + {{WLOG{1'b0}}, in_bit};
    assign samp_inc = samp_q + {{WLOG{1'b0}}, 1'b1};
    assign target   = {{WLOG{1'b0}}, 1'b1} << k_q;
    // count <= 2^k, so the shifted value never exceeds 2^WLOG and fits in WLOG+1 bits
    assign shamt    = KW'(WLOG) - k_q;
    assign scaled   = ones_inc << shamt;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        ones_d  = ones_q;
        samp_d  = samp_q;
        count_d = count_q;
        value_d = value_q;
        done_d  = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                    k_d     = k_clamp;
                    ones_d  = '0;
                    samp_d  = '0;
                end
            end
            StRun: begin
                if (start) begin
                    // restart: abandon the current window without a done pulse
                    k_d    = k_clamp;
                    ones_d = '0;
                    samp_d = '0;
                end else if (in_en) begin
                    ones_d = ones_inc;
                    samp_d = samp_inc;
                    if (samp_inc == target) begin
                        count_d = ones_inc;
                        value_d = scaled[WLOG] ? '1 : scaled[WLOG-1:0];
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            k_q     <= '0;
            ones_q  <= '0;
            samp_q  <= '0;
            count_q <= '0;
            value_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            ones_q  <= ones_d;
            samp_q  <= samp_d;
            count_q <= count_d;
            value_q <= value_d;
            done_q  <= done_d;
        end
    end

    assign busy      = (state_q == StRun);
    assign done      = done_q;
    assign count     = count_q;
    assign value     = value_q;
    assign ones_live = ones_q;

endmodule

// File: tb/tb_ustream_win_cnt.sv
// Scoreboard bench for ustream_win_cnt: a queue-based window model predicts
// each done pulse and the held outputs; a negedge monitor compares.
module tb_ustream_win_cnt;

    localparam int WLOG = 8;
    localparam int KW   = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic [KW-1:0]   win_log;
    logic            in_bit;
    logic            in_en;
    logic            busy;
    logic            done;
    logic [WLOG:0]   count;
    logic [WLOG-1:0] value;
    logic [WLOG:0]   ones_live;

    ustream_win_cnt #(.WLOG(WLOG), .KW(KW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .win_log   (win_log),
        .in_bit    (in_bit),
        .in_en     (in_en),
        .busy      (busy),
        .done      (done),
        .count     (count),
        .value     (value),
        .ones_live (ones_live)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cnt;
        int val;
        int edge_no;
    } exp_t;

    exp_t exp_q[$];
    bit   win[$];
    bit   m_running;
    int   m_k;
    int   m_live;
    int   m_count;
    int   m_value;
    int   edge_n;
    int   n_checks;
    int   n_fail;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    function automatic int ones_in_window();
        int s = 0;
        foreach (win[i]) s += int'(win[i]);
        return s;
    endfunction

    function automatic void model_reset();
        m_running = 1'b0;
        m_k       = 0;
        m_live    = 0;
        m_count   = 0;
        m_value   = 0;
        win.delete();
        exp_q.delete();
    endfunction

    // One clock edge of stimulus; the model is advanced by the spec's rules.
    task automatic step(input bit s, input int wl, input bit b, input bit en);
        exp_t e;
        start   = s;
        win_log = wl[KW-1:0];
        in_bit  = b;
        in_en   = en;
        @(posedge clk);
        edge_n++;
        if (rst_n) begin
            if (s) begin
                m_running = 1'b1;
                m_k       = (wl > WLOG) ? WLOG : wl;
                win.delete();
                m_live    = 0;
            end else if (m_running && en) begin
                win.push_back(b);
                m_live = ones_in_window();
                if (win.size() == (1 << m_k)) begin
                    e.cnt = m_live;
                    e.val = m_live * (1 << (WLOG - m_k));
                    if (e.val >= (1 << WLOG)) e.val = (1 << WLOG) - 1;
                    e.edge_no = edge_n;
                    exp_q.push_back(e);
                    m_count   = e.cnt;
                    m_value   = e.val;
                    m_running = 1'b0;
                end
            end
        end
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        chk("busy", int'(busy), int'(m_running));
        chk("ones_live", int'(ones_live), m_live);
        chk("count_hold", int'(count), m_count);
        chk("value_hold", int'(value), m_value);
        if (done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("done_edge", edge_n, e.edge_no);
                chk("done_count", int'(count), e.cnt);
                chk("done_value", int'(value), e.val);
            end
        end
    end

    initial begin
        bit pat[7];
        bit b8[8];
        rst_n   = 1'b0;
        start   = 1'b0;
        win_log = '0;
        in_bit  = 1'b0;
        in_en   = 1'b0;
        edge_n  = 0;
        model_reset();
        #1;
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_count", int'(count), 0);
        chk("reset_value", int'(value), 0);
        #12 rst_n = 1'b1;
        step(0, 0, 0, 0);

        // 1: k=3, bits 1,0,1,1,0,0,1,0 -> count 4, value 128; start-edge sample ignored
        b8 = '{1, 0, 1, 1, 0, 0, 1, 0};
        step(1, 3, 1, 1);
        foreach (b8[i]) step(0, 0, b8[i], 1);
        // back-to-back start in the done cycle
        step(1, 1, 1, 1);
        step(0, 0, 1, 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);

        // 2: k=8 all ones -> 256, saturated 255
        step(1, 8, 0, 0);
        for (int i = 0; i < 256; i++) step(0, 0, 1, 1);
        step(0, 0, 0, 0);

        // 3: k=2 gated by in_en
        pat = '{1, 0, 1, 0, 0, 1, 1};
        step(1, 2, 0, 0);
        foreach (pat[i]) step(0, 0, 1, pat[i]);
        step(0, 0, 0, 0);

        // 4: restart mid-window
        step(1, 4, 0, 0);
        step(0, 0, 1, 1);
        step(0, 0, 1, 1);
        step(1, 1, 1, 1);
        step(0, 0, 1, 1);
        step(0, 0, 1, 1);
        step(0, 0, 0, 0);

        // 5: k=0 single zero sample, then clamped win_log=12
        step(1, 0, 0, 0);
        step(0, 0, 0, 1);
        step(1, 12, 0, 0);
        for (int i = 0; i < 256; i++) step(0, 0, 0, 1);
        step(0, 0, 0, 0);

        // 6: reset at sample 5 of a k=3 window, then an alternating window
        step(1, 3, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 1);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_count", int'(count), 0);
        chk("midrst_value", int'(value), 0);
        step(0, 0, 1, 1);
        step(0, 0, 1, 1);
        #2 rst_n = 1'b1;
        step(1, 3, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 0, bit'(i % 2 == 0), 1);
        step(0, 0, 0, 0);

        // randomized traffic with occasional restarts and clamped lengths
        for (int i = 0; i < 3000; i++) begin
            bit s;
            int wl;
            s  = ($urandom_range(0, 99) < (m_running ? 2 : 25));
            wl = ($urandom_range(0, 9) == 0) ? $urandom_range(9, 15) : $urandom_range(0, 5);
            if (wl > WLOG) wl = (i % 4 == 0) ? wl : $urandom_range(0, 5);
            step(s, wl, 1'($urandom), $urandom_range(0, 3) != 0);
        end
        // let any in-flight window finish or go idle
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        if (!m_running) chk("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
